bus_requester: RTL and testbench
================================

Name: bus_requester

Overview:
- Requester-side client of the shared round-robin bus arbiter.
- Buffers bus commands from a local processing element in a small FIFO and raises o_req while it has work.
- Once granted, issues up to MAX_BURST beats onto the shared bus, then drops o_req for one cycle so the arbiter rotates to the next requester.
- One instance per PE port; o_req/i_grant connect to one bit of the arbiter's request/grant vectors.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, write-data width.
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.
- MAX_BURST, 4, maximum beats per grant tenure; ≥1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  PE command valid.
- o_cmd_ready  out  1  FIFO can accept a command.
- i_cmd_we  in  1  1 = write, 0 = read request.
- i_cmd_addr  in  ADDR_W  command address.
- i_cmd_wdata  in  DATA_W  command write data.
- o_req  out  1  request to arbiter.
- i_grant  in  1  grant from arbiter.
- o_bus_valid  out  1  beat valid on shared bus.
- o_bus_we  out  1  head command write-enable.
- o_bus_addr  out  ADDR_W  head command address.
- o_bus_wdata  out  DATA_W  head command data.
- i_bus_ready  in  1  bus accepts beat.
- o_busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset, async on i_rst_n low:
  - FIFO emptied; FSM enters IDLE; beat counter set to 0.
  - o_req=0, o_bus_valid=0, o_busy=0 immediately, without waiting for a clock edge.
  - o_cmd_ready=1 once reset is released.
- Push/pop:
  - Push occurs when i_cmd_valid & o_cmd_ready; o_cmd_ready = !full, with no bypass when full.
  - Pop occurs on a fire: o_bus_valid & i_bus_ready. Push and pop in the same cycle are both allowed.
  - Occupancy count is $clog2(FIFO_DEPTH+1) bits.
- Bus outputs: o_bus_we/addr/wdata always reflect the FIFO head. They stay stable while o_bus_valid & !i_bus_ready.
- FSM states: IDLE, REQ, BURST, RELEASE (enum, registered).
  - o_req = (state==REQ) | (state==BURST), decoded from the state register only.
  - o_bus_valid = (state==REQ | state==BURST) & i_grant & !empty.
  - IDLE: next state is REQ if not empty, else IDLE. A command pushed in cycle 0 gives o_req high in cycle 2.
  - REQ: on i_grant, go to BURST. A beat may fire in this same cycle and counts toward the burst.
  - BURST: on a fire with last-beat condition, go to RELEASE.
    - Last beat: beat_cnt==MAX_BURST-1, or (count==1 & no push this cycle).
    - A push coincident with the final pop keeps the burst going, subject to MAX_BURST.
  - BURST with i_grant low (protocol violation): go to REQ, beat_cnt set to 0, o_req stays high.
  - RELEASE: o_req=0 for exactly one cycle; i_grant is ignored (the arbiter's registered grant may still be high). Next state is REQ if not empty, else IDLE.
- Beat counter:
  - Width $clog2(MAX_BURST+1).
  - Increments on each fire; cleared on entry to RELEASE or REQ.
- Read responses travel on a separate return path outside this block; reads here are request beats only.

Decomposition:
- Package bus_req_pkg:
  - state_t enum {IDLE, REQ, BURST, RELEASE}.
  - cmd_t packed struct {we, addr[ADDR_W], wdata[DATA_W]}, parameterised via package localparams.
  - Default width constants.
- Sub-module cmd_fifo: synchronous FIFO of cmd_t with push/pop/full/empty/count and async active-low reset.
- The FSM and beat counter live in bus_requester.

Test Plan:
- Single write: push we=1 addr=0x10 data=0xAA; grant follows o_req one cycle later with bus_ready=1 → exactly one beat with addr 0x10 / data 0xAA; o_req low for one cycle; state returns to IDLE; o_busy=0.
- Burst cap: push 6 commands; grant follows req; bus_ready=1 → 4 beats; o_req low for exactly 1 cycle; then a second tenure of 2 beats; addresses in push order.
- Backpressure: during a burst, drop bus_ready for 3 cycles → o_bus_valid held high, addr/data unchanged, no pop, beat_cnt unchanged; transfer resumes when bus_ready returns.
- Full FIFO: DEPTH=4, no grant, push 5 commands → o_cmd_ready=0 after the 4th push; the 5th is accepted in the cycle after the first beat fires.
- Grant withdrawn mid-burst after 2 beats → o_bus_valid falls the same cycle; state goes to REQ with o_req high; on re-grant a fresh burst of up to 4 beats is issued.
- Async reset asserted mid-burst between clock edges → o_req, o_bus_valid and o_busy fall immediately; after release, FIFO is empty and o_cmd_ready=1.

Source files
------------

// File: rtl/bus_requester_pkg.sv
// Shared types and default widths for the bus requester slice.
// cmd_t is the unit stored in the command FIFO and presented on the shared bus.
package bus_req_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MAX_BURST  = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BURST,
    RELEASE
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/bus_requester_if.sv
// PE command port, arbiter request/grant pair and shared-bus beat port of one requester.
// master is the requester's view; slave is the PE/arbiter/bus side.
interface bus_requester_if
  import bus_req_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_we;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [DATA_W-1:0] i_cmd_wdata;

  logic              o_req;
  logic              i_grant;

  logic              o_bus_valid;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [DATA_W-1:0] o_bus_wdata;
  logic              i_bus_ready;

  logic              o_busy;

  modport master (
    input  i_cmd_valid,
    output o_cmd_ready,
    input  i_cmd_we,
    input  i_cmd_addr,
    input  i_cmd_wdata,
    output o_req,
    input  i_grant,
    output o_bus_valid,
    output o_bus_we,
    output o_bus_addr,
    output o_bus_wdata,
    input  i_bus_ready,
    output o_busy
  );

  modport slave (
    output i_cmd_valid,
    input  o_cmd_ready,
    output i_cmd_we,
    output i_cmd_addr,
    output i_cmd_wdata,
    input  o_req,
    output i_grant,
    input  o_bus_valid,
    input  o_bus_we,
    input  o_bus_addr,
    input  o_bus_wdata,
    output i_bus_ready,
    input  o_busy
  );

endinterface

// File: rtl/bus_requester_cmd_fifo.sv
// Synchronous command FIFO; the head entry is always visible on o_head.
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo
  import bus_req_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  cmd_t                       i_data,
  input  logic                       i_pop,
  output cmd_t                       o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // NOTE: storage carries no reset; only pointers and count define validity,
  // which keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({i_push, i_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_head  = mem[rd_ptr];
  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_empty = (count == '0);
  assign o_count = count;

endmodule

// File: rtl/bus_requester.sv
// Requester client of the shared round-robin arbiter: queues PE commands, requests the bus,
// issues up to MAX_BURST beats per grant, then drops o_req for one cycle so the arbiter rotates.
module bus_requester
  import bus_req_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  bus_requester_if.master   bus
);

  // cmd_t field widths come from the package; ADDR_W/DATA_W must match them.
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  state_t              state_q;
  state_t              state_d;
  logic [BCNT_W-1:0]   beat_cnt;

  cmd_t                push_cmd;
  cmd_t                head;
  logic                full;
  logic                empty;
  logic [FCNT_W-1:0]   fifo_count;

  logic                push;
  logic                fire;
  logic                last_beat;
  logic                req;
  logic                bus_valid;

  assign push_cmd = '{we: bus.i_cmd_we, addr: bus.i_cmd_addr, wdata: bus.i_cmd_wdata};
  assign push     = bus.i_cmd_valid && !full;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (push_cmd),
    .i_pop   (fire),
    .o_head  (head),
    .o_full  (full),
    .o_empty (empty),
    .o_count (fifo_count)
  );

  // A push alongside the final pop keeps the FIFO non-empty, so the tenure continues.
  assign last_beat = (beat_cnt == BCNT_W'(MAX_BURST - 1)) ||
                     ((fifo_count == FCNT_W'(1)) && !push);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    req       = (state_q == REQ) || (state_q == BURST);
    bus_valid = req && bus.i_grant && !empty;
    fire      = bus_valid && bus.i_bus_ready;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = REQ;
        end
      end
      REQ: begin
        // The granted cycle may already carry a beat, which may also be the last one.
        if (bus.i_grant) begin
          state_d = (fire && last_beat) ? RELEASE : BURST;
        end
      end
      BURST: begin
        if (!bus.i_grant) begin
          state_d = REQ;
        end else if (fire && last_beat) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // A lingering registered grant from the arbiter is ignored here.
        state_d = empty ? IDLE : REQ;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      beat_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d == RELEASE) || (state_d == REQ)) begin
        beat_cnt <= '0;
      end else if (fire) begin
        beat_cnt <= beat_cnt + BCNT_W'(1);
      end
    end
  end

  assign bus.o_cmd_ready = !full;
  assign bus.o_req       = req;
  assign bus.o_bus_valid = bus_valid;
  assign bus.o_bus_we    = head.we;
  assign bus.o_bus_addr  = ADDR_W'(head.addr);
  assign bus.o_bus_wdata = DATA_W'(head.wdata);
  assign bus.o_busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_bus_requester.sv
// Scoreboard bench for bus_requester: accepted commands are queued as expected beats and
// popped on every bus fire; a registered-grant arbiter model echoes o_req one cycle later.
module tb_bus_requester;
  import bus_req_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_requester_if bus ();

  bus_requester #(
    .ADDR_W     (DEF_ADDR_W),
    .DATA_W     (DEF_DATA_W),
    .FIFO_DEPTH (4),
    .MAX_BURST  (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  int   checks = 0;
  int   failures = 0;
  cmd_t pending_q[$];
  cmd_t exp_q[$];
  int   bursts[$];
  int   gaps[$];
  int   fires, pushes, cyc, cur_burst, low_run, first_push_cyc, first_req_cyc;
  logic arb_en, prev_req, seen_req;
  logic s_req, s_valid, s_busy, s_ready, s_fire, s_we;
  logic [DEF_ADDR_W-1:0] s_addr;
  logic [DEF_DATA_W-1:0] s_wdata;

  task automatic apply_pe();
    if (pending_q.size() != 0) begin
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_we    = pending_q[0].we;
      bus.i_cmd_addr  = pending_q[0].addr;
      bus.i_cmd_wdata = pending_q[0].wdata;
    end else begin
      bus.i_cmd_valid = 1'b0;
      bus.i_cmd_we    = 1'b0;
      bus.i_cmd_addr  = '0;
      bus.i_cmd_wdata = '0;
    end
  endtask

  function automatic void clear_stats();
    bursts.delete();
    gaps.delete();
    fires = 0; pushes = 0; cyc = 0; cur_burst = 0; low_run = 0;
    first_push_cyc = -1; first_req_cyc = -1; seen_req = 1'b0; prev_req = 1'b0;
  endfunction

  // One clock cycle: sample at the falling edge, score any beat, then drive the next inputs.
  task automatic tick();
    cmd_t e;
    @(negedge clk);
    s_req   = bus.o_req;
    s_valid = bus.o_bus_valid;
    s_busy  = bus.o_busy;
    s_ready = bus.o_cmd_ready;
    s_we    = bus.o_bus_we;
    s_addr  = bus.o_bus_addr;
    s_wdata = bus.o_bus_wdata;
    s_fire  = bus.o_bus_valid && bus.i_bus_ready;
    if (s_fire) begin
      checks++;
      fires++;
      cur_burst++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected: got addr=%h, no beat expected", s_addr);
      end else begin
        e = exp_q.pop_front();
        if ({s_we, s_addr, s_wdata} !== {e.we, e.addr, e.wdata}) begin
          failures++;
          $display("FAIL beat_payload: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                   s_we, s_addr, s_wdata, e.we, e.addr, e.wdata);
        end
      end
    end
    if (bus.i_cmd_valid && bus.o_cmd_ready) begin
      exp_q.push_back(pending_q.pop_front());
      pushes++;
      if (first_push_cyc < 0) first_push_cyc = cyc;
    end
    if (s_req && !prev_req) begin
      if (seen_req) gaps.push_back(low_run);
      seen_req = 1'b1;
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (!s_req && prev_req) begin
      bursts.push_back(cur_burst);
      cur_burst = 0;
    end
    low_run  = s_req ? 0 : low_run + 1;
    prev_req = s_req;
    @(posedge clk);
    #1;
    cyc++;
    bus.i_grant = arb_en && s_req;
    apply_pe();
  endtask

  task automatic drain(input int max_cycles, input string name);
    int n = 0;
    while ((pending_q.size() != 0 || exp_q.size() != 0 || bus.o_busy) && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (n >= max_cycles) begin
      failures++;
      $display("FAIL %s_drain: still busy after %0d cycles, %0d beats outstanding",
               name, n, exp_q.size());
    end
  endtask

  task automatic wait_fires(input int target, input string name);
    int n = 0;
    while (fires < target && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (fires < target) begin
      failures++;
      $display("FAIL %s_wait: got %0d beats, want %0d", name, fires, target);
    end
  endtask

  task automatic push_cmds(input int n, input logic [DEF_ADDR_W-1:0] base);
    cmd_t c;
    for (int i = 0; i < n; i++) begin
      c.we    = i[0];
      c.addr  = base + DEF_ADDR_W'(i * 4);
      c.wdata = $urandom;
      pending_q.push_back(c);
    end
    apply_pe();
  endtask

  task automatic test_reset();
    arb_en = 1'b0;
    bus.i_grant = 1'b0;
    bus.i_bus_ready = 1'b0;
    apply_pe();
    #2;
    checks++;
    if ({bus.o_req, bus.o_bus_valid, bus.o_busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs: got req/valid/busy=%b, want 000",
               {bus.o_req, bus.o_bus_valid, bus.o_busy});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_cmd_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b busy=%b, want ready=1 busy=0",
               bus.o_cmd_ready, bus.o_busy);
    end
  endtask

  task automatic test_single_write();
    cmd_t c;
    clear_stats();
    arb_en = 1'b1;
    bus.i_bus_ready = 1'b1;
    c.we = 1'b1; c.addr = 'h10; c.wdata = 'hAA;
    pending_q.push_back(c);
    apply_pe();
    drain(40, "single");
    checks++;
    if (fires !== 1) begin
      failures++;
      $display("FAIL single_beats: got %0d beats, want 1", fires);
    end
    checks++;
    if (first_req_cyc - first_push_cyc !== 2) begin
      failures++;
      $display("FAIL single_req_latency: got %0d cycles, want 2", first_req_cyc - first_push_cyc);
    end
    checks++;
    if (bursts.size() !== 1 || (bursts.size() == 1 && bursts[0] !== 1)) begin
      failures++;
      $display("FAIL single_tenure: got %0d tenures, want one of 1 beat", bursts.size());
    end
    checks++;
    if (bus.o_req !== 1'b0 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: got req=%b busy=%b, want 0 0", bus.o_req, bus.o_busy);
    end
  endtask

  task automatic test_burst_cap();
    clear_stats();
    arb_en = 1'b1;
    bus.i_bus_ready = 1'b1;
    push_cmds(6, 'h100);
    drain(80, "burst_cap");
    checks++;
    if (bursts.size() !== 2 || (bursts.size() == 2 && (bursts[0] !== 4 || bursts[1] !== 2))) begin
      failures++;
      $display("FAIL burst_cap_split: got %0d tenures (first %0d), want 4 then 2",
               bursts.size(), (bursts.size() > 0) ? bursts[0] : -1);
    end
    checks++;
    if (gaps.size() !== 1 || (gaps.size() == 1 && gaps[0] !== 1)) begin
      failures++;
      $display("FAIL burst_cap_release: got %0d gaps (first %0d), want one gap of 1 cycle",
               gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    logic [DEF_ADDR_W-1:0] hold_addr;
    logic [DEF_DATA_W-1:0] hold_data;
    clear_stats();
    arb_en = 1'b1;
    bus.i_bus_ready = 1'b1;
    push_cmds(6, 'h200);
    wait_fires(1, "stall");
    bus.i_bus_ready = 1'b0;
    hold_addr = exp_q[0].addr;
    hold_data = exp_q[0].wdata;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_addr !== hold_addr || s_wdata !== hold_data || fires !== 1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got valid=%b addr=%h beats=%0d, want valid=1 addr=%h beats=1",
                 i, s_valid, s_addr, fires, hold_addr);
      end
    end
    bus.i_bus_ready = 1'b1;
    drain(80, "stall");
    checks++;
    if (bursts.size() !== 2 || (bursts.size() == 2 && (bursts[0] !== 4 || bursts[1] !== 2))) begin
      failures++;
      $display("FAIL stall_burst_len: got %0d tenures (first %0d), want 4 then 2",
               bursts.size(), (bursts.size() > 0) ? bursts[0] : -1);
    end
  endtask

  task automatic test_full_fifo();
    clear_stats();
    arb_en = 1'b0;
    bus.i_grant = 1'b0;
    bus.i_bus_ready = 1'b1;
    push_cmds(5, 'h300);
    repeat (6) tick();
    checks++;
    if (pushes !== 4 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_block: got pushes=%0d ready=%b, want pushes=4 ready=0", pushes, s_ready);
    end
    arb_en = 1'b1;
    wait_fires(1, "full");
    checks++;
    if (pushes !== 4 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_no_bypass: got pushes=%0d ready=%b in first-beat cycle, want 4 and 0",
               pushes, s_ready);
    end
    tick();
    checks++;
    if (pushes !== 5 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_accept_next: got pushes=%0d ready=%b, want 5 and 1", pushes, s_ready);
    end
    drain(80, "full");
  endtask

  task automatic test_grant_withdraw();
    clear_stats();
    arb_en = 1'b1;
    bus.i_bus_ready = 1'b1;
    push_cmds(6, 'h400);
    wait_fires(2, "withdraw");
    arb_en = 1'b0;
    bus.i_grant = 1'b0;
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || fires !== 2) begin
      failures++;
      $display("FAIL withdraw_same_cycle: got valid=%b req=%b beats=%0d, want 0 1 2",
               s_valid, s_req, fires);
    end
    tick();
    checks++;
    if (s_req !== 1'b1 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_req_state: got req=%b valid=%b, want 1 0", s_req, s_valid);
    end
    arb_en = 1'b1;
    drain(80, "withdraw");
    checks++;
    if (bursts.size() !== 1 || (bursts.size() == 1 && bursts[0] !== 6)) begin
      failures++;
      $display("FAIL withdraw_fresh_burst: got %0d tenures (first %0d), want one of 2+4 beats",
               bursts.size(), (bursts.size() > 0) ? bursts[0] : -1);
    end
  endtask

  task automatic test_async_reset();
    clear_stats();
    arb_en = 1'b1;
    bus.i_bus_ready = 1'b1;
    push_cmds(6, 'h500);
    wait_fires(1, "areset");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_req, bus.o_bus_valid, bus.o_busy} !== 3'b000) begin
      failures++;
      $display("FAIL areset_immediate: got req/valid/busy=%b, want 000",
               {bus.o_req, bus.o_bus_valid, bus.o_busy});
    end
    pending_q.delete();
    exp_q.delete();
    apply_pe();
    arb_en = 1'b0;
    bus.i_grant = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_cmd_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_req !== 1'b0) begin
      failures++;
      $display("FAIL areset_release: got ready=%b busy=%b req=%b, want 1 0 0",
               bus.o_cmd_ready, bus.o_busy, bus.o_req);
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_single_write();
    test_burst_cap();
    test_backpressure();
    test_full_fifo();
    test_grant_withdraw();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
